// File: rtl/issue2_pair_fetch_buffer.sv
// Instruction fetch queue feeding a primary issue slot plus an optional second (dual-issue) slot.
// Optional dual-issue pair counter is built when ISSUE2_PAIR_STATS_EN is defined.
module issue2_pair_fetch_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_ready_o,
    output logic        pi_valid_o,
    output logic [31:0] pi_instr_o,
    output logic [31:0] pi_addr_o,
    output logic        i2_valid_o,
    output logic [31:0] i2_instr_o,
    output logic [31:0] i2_addr_o,
    output logic        in_line_ok_o,
    input  logic        id_ready_i,
    input  logic        i2_take_i,
    output logic [31:0] dual_pair_cnt_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic [31:0]     word_q [DEPTH];
    logic [31:0]     addr_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_nx;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] pop_cnt;
    logic            push;
    logic            pop_any;
    logic            pop_two;

    assign rd_ptr_nx = rd_ptr_q + PtrW'(1);

    always_comb begin
        // Readiness looks only at the registered fill level; a pop this cycle gives no credit.
        fetch_ready_o = !flush_i && (count_q < DepthC);
        push          = fetch_valid_i && fetch_ready_o;

        pi_valid_o = (count_q != '0);
        i2_valid_o = (count_q >= CntW'(2));
        pi_instr_o = pi_valid_o ? word_q[rd_ptr_q]  : 32'h0;
        pi_addr_o  = pi_valid_o ? addr_q[rd_ptr_q]  : 32'h0;
        i2_instr_o = i2_valid_o ? word_q[rd_ptr_nx] : 32'h0;
        i2_addr_o  = i2_valid_o ? addr_q[rd_ptr_nx] : 32'h0;

        in_line_ok_o = pi_valid_o && i2_valid_o
                    && (i2_addr_o == pi_addr_o + 32'd4)
                    && (pi_instr_o[1:0] == 2'b11)
                    && (i2_instr_o[1:0] == 2'b11);

        pop_any = pi_valid_o && id_ready_i;
        pop_two = pop_any && i2_take_i && in_line_ok_o;
        pop_cnt = pop_two ? CntW'(2) : (pop_any ? CntW'(1) : '0);
    end

    always_comb begin
        count_d  = count_q + CntW'(push) - pop_cnt;
        rd_ptr_d = rd_ptr_q + PtrW'(pop_cnt);
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is not reset: the zero count already hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= fetch_rdata_i;
            addr_q[wr_ptr_q] <= fetch_addr_i;
        end
    end

`ifdef ISSUE2_PAIR_STATS_EN
    logic [31:0] pair_cnt_q, pair_cnt_d;

    // A flush cancels the pop, so no pair is counted in that cycle.
    always_comb begin
        pair_cnt_d = pair_cnt_q;
        if (pop_two && !flush_i && (pair_cnt_q != 32'hFFFF_FFFF)) begin
            pair_cnt_d = pair_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt_q <= 32'h0;
        end else begin
            pair_cnt_q <= pair_cnt_d;
        end
    end

    assign dual_pair_cnt_o = pair_cnt_q;
`else
    assign dual_pair_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_issue2_pair_fetch_buffer.sv
// Self-checking bench for issue2_pair_fetch_buffer against a queue-based reference model.
module tb_issue2_pair_fetch_buffer;

    localparam int unsigned DEPTH = 4;
`ifdef ISSUE2_PAIR_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic [31:0] fetch_addr_i = 32'h0;
    logic        fetch_ready_o;
    logic        pi_valid_o;
    logic [31:0] pi_instr_o;
    logic [31:0] pi_addr_o;
    logic        i2_valid_o;
    logic [31:0] i2_instr_o;
    logic [31:0] i2_addr_o;
    logic        in_line_ok_o;
    logic        id_ready_i = 1'b0;
    logic        i2_take_i = 1'b0;
    logic [31:0] dual_pair_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mstat = 32'h0;

    issue2_pair_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_rdata_i  (fetch_rdata_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_ready_o  (fetch_ready_o),
        .pi_valid_o     (pi_valid_o),
        .pi_instr_o     (pi_instr_o),
        .pi_addr_o      (pi_addr_o),
        .i2_valid_o     (i2_valid_o),
        .i2_instr_o     (i2_instr_o),
        .i2_addr_o      (i2_addr_o),
        .in_line_ok_o   (in_line_ok_o),
        .id_ready_i     (id_ready_i),
        .i2_take_i      (i2_take_i),
        .dual_pair_cnt_o(dual_pair_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: the queue contents decide every output.
    function automatic logic m_inline();
        if (mq.size() < 2) return 1'b0;
        return (mq[1].a == mq[0].a + 32'd4) && (mq[0].w[1:0] == 2'b11) && (mq[1].w[1:0] == 2'b11);
    endfunction

    function automatic logic [163:0] m_outputs();
        logic [31:0] pw, pa, sw, sa;
        pw = (mq.size() >= 1) ? mq[0].w : 32'h0;
        pa = (mq.size() >= 1) ? mq[0].a : 32'h0;
        sw = (mq.size() >= 2) ? mq[1].w : 32'h0;
        sa = (mq.size() >= 2) ? mq[1].a : 32'h0;
        return {!flush_i && (mq.size() < DEPTH), mq.size() >= 1, mq.size() >= 2, m_inline(),
                pw, pa, sw, sa, mstat};
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] a,
                         input logic r, input logic t, input logic f);
        @(negedge clk);
        fetch_valid_i = v;
        fetch_rdata_i = w;
        fetch_addr_i  = a;
        id_ready_i    = r;
        i2_take_i     = t;
        flush_i       = f;
        #1;
    endtask

    task automatic commit();
        int   n_pop;
        logic do_push;
        ent_t e;
        do_push = fetch_valid_i && !flush_i && (mq.size() < DEPTH);
        n_pop = 0;
        if (mq.size() >= 1 && id_ready_i) n_pop = (i2_take_i && m_inline()) ? 2 : 1;
        e.w = fetch_rdata_i;
        e.a = fetch_addr_i;
        @(posedge clk);
        if (flush_i) begin
            mq.delete();
        end else begin
            repeat (n_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
            if (n_pop == 2 && StatsEn && mstat != 32'hFFFF_FFFF) mstat = mstat + 32'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'hDEAD_BEEF;
        fetch_addr_i  = 32'h0000_0040;
        flush_i = 1'b1;
        id_ready_i = 1'b0;
        i2_take_i = 1'b0;
        repeat (2) @(posedge clk);
        mq.delete();
        mstat = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        fetch_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [163:0] got;
        do_reset();
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        got = {fetch_ready_o, pi_valid_o, i2_valid_o, in_line_ok_o, pi_instr_o, pi_addr_o,
               i2_instr_o, i2_addr_o, dual_pair_cnt_o};
        n_checks++;
        if (got !== {1'b1, 3'b000, 160'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", got, {1'b1, 3'b000, 160'h0});
        end
        commit();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            drive(0, 32'h0, 32'h0, 1, 0, 0);
            commit();
        end
    endtask

    task automatic test_pair();
        drive(1, 32'h00A0_0093, 32'h100, 0, 0, 0);
        commit();
        drive(1, 32'h0010_8113, 32'h104, 0, 0, 0);
        commit();
        drive(0, 32'h0, 32'h0, 1, 1, 0);
        n_checks++;
        if (in_line_ok_o !== 1'b1 || i2_addr_o !== 32'h104) begin
            n_fail++;
            $display("FAIL pair_inline: in_line_ok %b i2_addr %h required 1 / 00000104",
                     in_line_ok_o, i2_addr_o);
        end
        commit();
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        n_checks++;
        if (pi_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pair_popped: pi_valid %b ready %b required 0 / 1", pi_valid_o,
                     fetch_ready_o);
        end
        n_checks++;
        if (dual_pair_cnt_o !== mstat) begin
            n_fail++;
            $display("FAIL pair_count: got %0d required %0d", dual_pair_cnt_o, mstat);
        end
        commit();
    endtask

    task automatic test_nonseq();
        drive(1, 32'h0000_0013, 32'h100, 0, 0, 0);
        commit();
        drive(1, 32'h0000_0093, 32'h108, 0, 0, 0);
        commit();
        drive(0, 32'h0, 32'h0, 1, 1, 0);
        n_checks++;
        if (in_line_ok_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nonseq_inline: got %b required 0", in_line_ok_o);
        end
        commit();
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        n_checks++;
        if (pi_valid_o !== 1'b1 || pi_addr_o !== 32'h108 || i2_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nonseq_single_pop: valid %b addr %h i2 %b required 1 00000108 0",
                     pi_valid_o, pi_addr_o, i2_valid_o);
        end
        commit();
        drain();
    endtask

    task automatic test_compressed();
        drive(1, 32'h0000_4501, 32'h200, 0, 0, 0);
        commit();
        drive(1, 32'h0000_0013, 32'h204, 0, 0, 0);
        commit();
        drive(0, 32'h0, 32'h0, 1, 1, 0);
        n_checks++;
        if (in_line_ok_o !== 1'b0 || pi_instr_o !== 32'h0000_4501) begin
            n_fail++;
            $display("FAIL compressed_inline: inline %b instr %h required 0 / 00004501",
                     in_line_ok_o, pi_instr_o);
        end
        commit();
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        n_checks++;
        if (pi_addr_o !== 32'h204 || i2_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL compressed_single_pop: addr %h i2 %b required 00000204 / 0",
                     pi_addr_o, i2_valid_o);
        end
        commit();
        drain();
    endtask

    task automatic test_full();
        logic [31:0] exp_w[4];
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h13 + 32'(i) * 32'h100, 32'h300 + 32'(i) * 32'd4, 0, 0, 0);
            n_checks++;
            if (fetch_ready_o !== (i < 4)) begin
                n_fail++;
                $display("FAIL full_ready[%0d]: got %b required %b", i, fetch_ready_o, i < 4);
            end
            commit();
        end
        drive(1, 32'h0000_0613, 32'h318, 1, 0, 0);
        n_checks++;
        if (fetch_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_pop_credit: got %b required 0", fetch_ready_o);
        end
        commit();
        drive(1, 32'h0000_0713, 32'h31C, 0, 0, 0);
        n_checks++;
        if (fetch_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_slot_freed: got %b required 1", fetch_ready_o);
        end
        commit();
        exp_w = '{32'h0000_0113, 32'h0000_0213, 32'h0000_0313, 32'h0000_0713};
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 32'h0, 1, 0, 0);
            n_checks++;
            if (pi_valid_o !== 1'b1 || pi_instr_o !== exp_w[i]) begin
                n_fail++;
                $display("FAIL full_order[%0d]: valid %b instr %h required 1 / %h", i,
                         pi_valid_o, pi_instr_o, exp_w[i]);
            end
            commit();
        end
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        n_checks++;
        if (pi_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: pi_valid %b required 0", pi_valid_o);
        end
        commit();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_0013, 32'h400 + 32'(i) * 32'd4, 0, 0, 0);
            commit();
        end
        drive(1, 32'h0000_0893, 32'h40C, 1, 0, 1);
        n_checks++;
        if (fetch_ready_o !== 1'b0 || pi_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle: ready %b valid %b required 0 / 1", fetch_ready_o,
                     pi_valid_o);
        end
        commit();
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        n_checks++;
        if (pi_valid_o !== 1'b0 || i2_valid_o !== 1'b0 || fetch_ready_o !== 1'b1
            || pi_instr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_empty: valid %b i2 %b ready %b instr %h required 0 0 1 0",
                     pi_valid_o, i2_valid_o, fetch_ready_o, pi_instr_o);
        end
        commit();
    endtask

    task automatic test_wrap();
        drive(1, 32'h0000_0013, 32'hFFFF_FFFC, 0, 0, 0);
        commit();
        drive(1, 32'h0000_0093, 32'h0000_0000, 0, 0, 0);
        commit();
        drive(0, 32'h0, 32'h0, 1, 1, 0);
        n_checks++;
        if (in_line_ok_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_inline: got %b required 1", in_line_ok_o);
        end
        commit();
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        n_checks++;
        if (pi_valid_o !== 1'b0 || dual_pair_cnt_o !== mstat) begin
            n_fail++;
            $display("FAIL wrap_pop2: valid %b count %0d required 0 / %0d", pi_valid_o,
                     dual_pair_cnt_o, mstat);
        end
        commit();
    endtask

    task automatic test_random();
        logic [31:0]  next_a;
        logic [31:0]  w, a;
        logic [163:0] got, exp;
        next_a = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            w[1:0] = ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b11;
            case ($urandom_range(0, 9))
                0:       a = $urandom & 32'hFFFF_FFFC;
                1:       a = 32'hFFFF_FFF8;
                default: a = next_a;
            endcase
            next_a = a + 32'd4;
            drive($urandom_range(0, 3) != 0, w, a, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
            got = {fetch_ready_o, pi_valid_o, i2_valid_o, in_line_ok_o, pi_instr_o, pi_addr_o,
                   i2_instr_o, i2_addr_o, dual_pair_cnt_o};
            exp = m_outputs();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", i, got, exp);
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_nonseq();
        test_compressed();
        test_full();
        test_flush();
        test_wrap();
        test_random();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue2_pair_fetch_buffer.md
ISSUE2_PAIR_FETCH_BUFFER -- requirements
Module: issue2_pair_fetch_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning the instruction-queue entry count; legal values are powers of two from 2 to 16.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL provide port flush_i, input, 1, branch/exception flush that discards all queued entries.
REQ-005 SHALL provide port fetch_valid_i, input, 1, fetch word valid.
REQ-006 SHALL provide port fetch_rdata_i, input, 32, fetched instruction word.
REQ-007 SHALL provide port fetch_addr_i, input, 32, byte address of fetch_rdata_i.
REQ-008 SHALL provide port fetch_ready_o, output, 1, buffer can accept a word this cycle.
REQ-009 SHALL provide port pi_valid_o, input-side primary-issue valid, output, 1.
REQ-010 SHALL provide ports pi_instr_o and pi_addr_o, output, 32 each, head entry word and address.
REQ-011 SHALL provide port i2_valid_o, output, 1, second entry present.
REQ-012 SHALL provide ports i2_instr_o and i2_addr_o, output, 32 each, second entry word and address.
REQ-013 SHALL provide port in_line_ok_o, output, 1, head and second entry form a sequential uncompressed pair, fed to the issue2 allocator.
REQ-014 SHALL provide port id_ready_i, input, 1, decode accepts the primary instruction this cycle.
REQ-015 SHALL provide port i2_take_i, input, 1, allocator granted dual issue of the second entry this cycle.
REQ-016 SHALL provide port dual_pair_cnt_o, output, 32, count of dual-issued pairs.

Function
REQ-017 SHALL hold up to DEPTH entries {word, addr} in a circular queue with read pointer, write pointer (both wrap modulo DEPTH) and count 0..DEPTH.
REQ-018 SHALL drive fetch_ready_o = !flush_i && (count < DEPTH), based on registered count only; no same-cycle pop credit.
REQ-019 SHALL push when fetch_valid_i && fetch_ready_o, writing at write pointer, visible on outputs next cycle (1-cycle latency, no bypass).
REQ-020 SHALL drive pi_valid_o = (count >= 1) and i2_valid_o = (count >= 2), combinationally from state.
REQ-021 SHALL drive pi_*/i2_* outputs from read pointer and read pointer+1; outputs of an invalid slot SHALL be 32'h0.
REQ-022 SHALL drive in_line_ok_o = pi_valid_o && i2_valid_o && (i2_addr_o == pi_addr_o + 32'd4, modulo 2^32) && pi_instr_o[1:0]==2'b11 && i2_instr_o[1:0]==2'b11.
REQ-023 SHALL pop 0 entries when !(pi_valid_o && id_ready_i); else pop 2 when i2_take_i && in_line_ok_o; else pop 1 (i2_take_i ignored when in_line_ok_o is low).
REQ-024 SHALL update count_next = count + push - pop with simultaneous push and pop legal at any fill, including full-with-pop (push blocked per REQ-018) and empty-with-push.
REQ-025 SHALL, on flush_i, set count and both pointers to 0 next cycle, ignoring any push or pop in that cycle.
REQ-026 SHALL never pop more than count and never push when count == DEPTH.

Reset
REQ-027 SHALL on rst set count, read pointer, write pointer and dual_pair_cnt_o to 0; entry storage need not be reset.
REQ-028 SHALL after rst show fetch_ready_o=1, pi_valid_o=0, i2_valid_o=0, in_line_ok_o=0, all data outputs 0; rst dominates flush_i and push.

Configuration
REQ-029 SHALL, when macro ISSUE2_PAIR_STATS_EN is defined, increment dual_pair_cnt_o by 1 on every 2-entry pop, saturating at 32'hFFFF_FFFF, cleared only by rst (not by flush_i).
REQ-030 SHALL, when ISSUE2_PAIR_STATS_EN is undefined, tie dual_pair_cnt_o to 32'h0 and implement no counter flops.

Verification
REQ-031 SHALL cover: reset, push 0x00A00093@0x100 then 0x00108113@0x104, id_ready_i=1, i2_take_i=1 -> cycle after second push in_line_ok_o=1, both popped, count 0, dual_pair_cnt_o=1 (stats on).
REQ-032 SHALL cover: entries @0x100 and @0x108 (non-sequential), i2_take_i=1 -> in_line_ok_o=0, only one pop, next pi_addr_o=0x108.
REQ-033 SHALL cover: head word 0x00004501 (compressed, [1:0]=01) -> in_line_ok_o=0, single pop.
REQ-034 SHALL cover: DEPTH=4, fetch_valid_i held 1, id_ready_i=0 -> fetch_ready_o drops after 4 pushes; one pop then frees one slot next cycle, no word lost or duplicated.
REQ-035 SHALL cover: 3 entries queued, flush_i=1 with fetch_valid_i=1 and id_ready_i=1 -> next cycle count 0, pi_valid_o=0, pushed word discarded.
REQ-036 SHALL cover: address wrap pair 0xFFFFFFFC/0x00000000 uncompressed -> in_line_ok_o=1; stats build without macro -> dual_pair_cnt_o stays 0.
